muldiv_sequencer: RTL and testbench

Iterative HI/LO multiply/divide unit and its sequencer for the mips_r2000 pipeline. It executes MULT, MULTU, DIV and DIVU one bit per cycle and owns the architectural HI and LO registers. It sits beside the execute stage. It raises stall to the pipeline when an instruction needs HI/LO, or needs a new operation, while a previous operation is still running.

---
 rtl/muldiv_sequencer_if.sv | 29 ++
 rtl/muldiv_sequencer.sv | 152 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Pipeline-side bundle for the HI/LO multiply/divide unit: issue, MTHI/MTLO
// writes, MFHI/MFLO read requests, and the HI/LO/status return path.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             read_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;

    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo, wdata, read_req,
        input  hi, lo, busy, stall, done
    );

    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo, wdata, read_req,
        output hi, lo, busy, stall, done
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one bit per cycle on
// operand magnitudes, with sign correction in a final FIX cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    muldiv_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     orig_a_q, orig_a_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 op_signed;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]     quot, rem;
    logic                 busy;

    assign busy      = (state_q != IDLE);
    assign bus.busy  = busy;
    assign bus.stall = busy & (bus.read_req | bus.start | bus.mthi | bus.mtlo);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.done  = done_q;

    // MULT and DIV (op[0]=0) are signed; magnitudes are taken at issue time.
    assign op_signed = ~bus.op[0];
    assign a_mag = (op_signed && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    assign b_mag = (op_signed && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;

    // acc holds {upper, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        mul_res   = neg_res_q ? -acc_q : acc_q;
        quot      = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        mcand_d    = mcand_q;
        orig_a_d   = orig_a_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_div_d   = bus.op[1];
                    neg_res_d  = op_signed & (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
                    neg_rem_d  = op_signed & bus.rs_data[WIDTH-1];
                    div_zero_d = (bus.rt_data == '0);
                    orig_a_d   = bus.rs_data;
                    count_d    = CW'(WIDTH);
                    if (bus.op[1]) begin
                        mcand_d = b_mag;
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        mcand_d = a_mag;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                    end
                    state_d = RUN;
                end else begin
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    // Restoring step: keep the trial difference only when it did not borrow.
                    if (!div_diff[WIDTH])
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                if (!is_div_q) begin
                    hi_d = mul_res[2*WIDTH-1:WIDTH];
                    lo_d = mul_res[WIDTH-1:0];
                end else if (div_zero_q) begin
                    hi_d = orig_a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quot;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            mcand_q    <= '0;
            orig_a_q   <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            mcand_q    <= mcand_d;
            orig_a_q   <= orig_a_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, divide corner cases,
// stall behaviour and mid-operation reset.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    // Issues one operation (caller is just after a rising edge) and waits for busy to drop.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] hi, output logic [W-1:0] lo,
                          output int busy_cnt, output logic done_now, output logic done_after);
        bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_cnt = 0;
        while (bus.busy && busy_cnt < 100) begin
            busy_cnt++;
            @(posedge clk); #1;
        end
        done_now = bus.done; hi = bus.hi; lo = bus.lo;
        @(posedge clk); #1;
        done_after = bus.done;
        $display("op=%b a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", op, a, b, hi, lo, busy_cnt);
    endtask

    task automatic check_vec(input string name, input vec_t v);
        logic [W-1:0] hi, lo;
        int bc;
        logic dn, da;
        run_op(v.op, v.a, v.b, hi, lo, bc, dn, da);
        checks++; if (bc !== W + 1) begin errors++; $display("FAIL %s busy: got %0d expected %0d", name, bc, W + 1); end
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL %s done: got %b expected 1", name, dn); end
        checks++; if (hi !== v.hi) begin errors++; $display("FAIL %s hi: got %h expected %h", name, hi, v.hi); end
        checks++; if (lo !== v.lo) begin errors++; $display("FAIL %s lo: got %h expected %h", name, lo, v.lo); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b expected 0", name, da); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 0; bus.op = 0; bus.rs_data = 0; bus.rt_data = 0;
        bus.mthi = 0; bus.mtlo = 0; bus.wdata = 0; bus.read_req = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        bus.read_req = 1'b1;
        #1;
        $display("reset: hi=%h lo=%h busy=%b done=%b stall=%b", bus.hi, bus.lo, bus.busy, bus.done, bus.stall);
        checks++; if (bus.hi !== '0) begin errors++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
        checks++; if (bus.lo !== '0) begin errors++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
        bus.read_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_multiply();
        vec_t v[3];
        v[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        v[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        v[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        for (int i = 0; i < 3; i++) check_vec($sformatf("mul%0d", i), v[i]);
    endtask

    task automatic test_divide();
        vec_t v[6];
        v[0] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        v[1] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        v[2] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        v[3] = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        v[4] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        v[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        for (int i = 0; i < 6; i++) check_vec($sformatf("div%0d", i), v[i]);
    endtask

    task automatic test_stall();
        int cyc, stall_bad, hold_bad, done_cnt, busy_after;
        bus.mthi = 1; bus.mtlo = 1; bus.wdata = 32'hA5A5_0F0F;
        @(posedge clk); #1;
        bus.mthi = 0; bus.mtlo = 0;
        $display("mthi+mtlo: hi=%h lo=%h done=%b", bus.hi, bus.lo, bus.done);
        checks++; if (bus.hi !== 32'hA5A5_0F0F) begin errors++; $display("FAIL mtboth_hi: got %h expected a5a50f0f", bus.hi); end
        checks++; if (bus.lo !== 32'hA5A5_0F0F) begin errors++; $display("FAIL mtboth_lo: got %h expected a5a50f0f", bus.lo); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mtboth_done: got %b expected 0", bus.done); end

        bus.start = 1; bus.op = 2'b11; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
        @(posedge clk); #1;
        bus.start = 0;
        cyc = 1; stall_bad = 0; hold_bad = 0;
        while (bus.busy && cyc < 100) begin
            if (cyc == 2) bus.read_req = 1'b1;
            if (cyc >= 5 && cyc <= 7) begin
                bus.start = 1; bus.op = 2'b11; bus.rs_data = 32'd50; bus.rt_data = 32'd3;
            end else begin
                bus.start = 0;
            end
            #1;
            if (bus.stall !== (cyc >= 2)) stall_bad++;
            if (bus.hi !== 32'hA5A5_0F0F || bus.lo !== 32'hA5A5_0F0F) hold_bad++;
            @(posedge clk); #1;
            cyc++;
        end
        $display("stall run: done_cycle=%0d stall=%b done=%b hi=%h lo=%h", cyc, bus.stall, bus.done, bus.hi, bus.lo);
        checks++; if (cyc !== W + 2) begin errors++; $display("FAIL stall_latency: got %0d expected %0d", cyc, W + 2); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_busy: got %0d bad cycles expected 0", stall_bad); end
        checks++; if (hold_bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles expected 0", hold_bad); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL stall_done_cycle: got %b expected 0", bus.stall); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", bus.done); end
        checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL stall_lo: got %h expected 0000000e", bus.lo); end
        checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL stall_hi: got %h expected 00000002", bus.hi); end
        bus.read_req = 0;
        done_cnt = 0; busy_after = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
            if (bus.busy) busy_after++;
        end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL second_start_done: got %0d extra pulses expected 0", done_cnt); end
        checks++; if (busy_after !== 0) begin errors++; $display("FAIL second_start_busy: got %0d busy cycles expected 0", busy_after); end
    endtask

    task automatic test_reset_mid();
        int done_cnt, busy_cnt;
        bus.start = 1; bus.op = 2'b00; bus.rs_data = 32'hFFFF_FFFD; bus.rt_data = 32'd7;
        @(posedge clk); #1;
        bus.start = 0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("mid reset: busy=%b hi=%h lo=%h done=%b", bus.busy, bus.hi, bus.lo, bus.done);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.hi !== '0) begin errors++; $display("FAIL midrst_hi: got %h expected 0", bus.hi); end
        checks++; if (bus.lo !== '0) begin errors++; $display("FAIL midrst_lo: got %h expected 0", bus.lo); end
        done_cnt = 0; busy_cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
            if (bus.busy) busy_cnt++;
        end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midrst_nodone: got %0d pulses expected 0", done_cnt); end
        checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL midrst_idle: got %0d busy cycles expected 0", busy_cnt); end

        bus.mthi = 1; bus.wdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus.mthi = 0;
        $display("mthi: hi=%h lo=%h done=%b", bus.hi, bus.lo, bus.done);
        checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi: got %h expected 12345678", bus.hi); end
        checks++; if (bus.lo !== '0) begin errors++; $display("FAIL mthi_lo: got %h expected 0", bus.lo); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mthi_done: got %b expected 0", bus.done); end

        bus.start = 1; bus.op = 2'b01; bus.rs_data = 32'd2; bus.rt_data = 32'd3;
        bus.mtlo = 1; bus.wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.start = 0; bus.mtlo = 0;
        $display("start+mtlo: busy=%b lo=%h", bus.busy, bus.lo);
        checks++; if (bus.lo !== '0) begin errors++; $display("FAIL start_mtlo_lo: got %h expected 0", bus.lo); end
        busy_cnt = 0;
        while (bus.busy && busy_cnt < 100) begin busy_cnt++; @(posedge clk); #1; end
        $display("start+mtlo result: hi=%h lo=%h done=%b", bus.hi, bus.lo, bus.done);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL start_mtlo_done: got %b expected 1", bus.done); end
        checks++; if (bus.lo !== 32'd6) begin errors++; $display("FAIL start_mtlo_res: got %h expected 00000006", bus.lo); end
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL start_mtlo_hi: got %h expected 0", bus.hi); end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
